// File: rtl/pll_i2c_scheduler.sv
// pll_i2c_scheduler
// Shares the single PLL-A I2C master between the boot ROM walker and the
// software register poke. Every grant becomes one two-byte I2C write
// {reg, value}. Arbitration is round-robin, except that a boot burst keeps
// the bus until boot_last so that PLL configuration is never interleaved
// with software writes.
// Optional feature macro: PLL_I2C_SCHED_RETRY_EN
//   defined   : a NACKed transaction is replayed after a STOP gap, up to
//               MAX_RETRY times; err is reported only if the last attempt
//               also NACKs. Timeouts are never replayed.
//   undefined : the first NACK completes the transaction with err=1.

module pll_i2c_scheduler #(
    parameter logic [6:0] I2C_ADDR       = 7'h60,
    parameter int         GAP_CYCLES     = 4,
    parameter int         TIMEOUT_CYCLES = 65535,
    parameter int         MAX_RETRY      = 3
) (
    input  logic       clk_i,
    input  logic       nreset_i,

    input  logic       boot_req_i,
    input  logic [7:0] boot_reg_i,
    input  logic [7:0] boot_value_i,
    input  logic       boot_last_i,
    output logic       boot_ack_o,
    output logic       boot_err_o,

    input  logic       sw_req_i,
    input  logic [7:0] sw_reg_i,
    input  logic [7:0] sw_value_i,
    output logic       sw_ack_o,
    output logic       sw_err_o,

    output logic       busy_o,

    output logic       i2c_cmd_active_o,
    output logic [6:0] i2c_cmd_addr_o,
    output logic       i2c_data_valid_o,
    output logic [7:0] i2c_data_in_o,
    input  logic       i2c_data_ready_i,
    input  logic       i2c_addr_err_i,
    input  logic       i2c_data_err_i
);

    // Counter widths: each counter only has to reach its limit minus one.
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GRANT,
        S_REG,
        S_VAL,
        S_DONE,
        S_GAP
    } state_t;

    state_t          state_q, state_d;
    logic            owner_sw_q, owner_sw_d;
    logic            last_sw_q, last_sw_d;
    logic            lock_q, lock_d;
    logic [7:0]      reg_q, reg_d;
    logic [7:0]      val_q, val_d;
    logic            blast_q, blast_d;
    logic            err_q, err_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic [GW-1:0]   gap_q, gap_d;

    logic            grant_boot;
    logic            grant_sw;
    logic            nack;
    logic            can_retry;

`ifdef PLL_I2C_SCHED_RETRY_EN
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    logic [RW-1:0]   retry_q, retry_d;
    logic            again_q, again_d;

    assign can_retry = (retry_q < RW'(MAX_RETRY));
`else
    logic            unused_cfg;

    assign can_retry  = 1'b0;
    assign unused_cfg = (MAX_RETRY != 0);
`endif

    // While locked only boot may win; otherwise the port not granted last wins a tie.
    assign grant_boot = boot_req_i && (lock_q || !sw_req_i || last_sw_q);
    assign grant_sw   = sw_req_i && !lock_q && (!boot_req_i || !last_sw_q);
    assign nack       = i2c_addr_err_i || i2c_data_err_i;

    // State and datapath registers; reset drops the bus immediately with no ack.
    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            state_q    <= S_IDLE;
            owner_sw_q <= 1'b0;
            last_sw_q  <= 1'b1;
            lock_q     <= 1'b0;
            reg_q      <= 8'h00;
            val_q      <= 8'h00;
            blast_q    <= 1'b0;
            err_q      <= 1'b0;
            tmo_q      <= '0;
            gap_q      <= '0;
`ifdef PLL_I2C_SCHED_RETRY_EN
            retry_q    <= '0;
            again_q    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            owner_sw_q <= owner_sw_d;
            last_sw_q  <= last_sw_d;
            lock_q     <= lock_d;
            reg_q      <= reg_d;
            val_q      <= val_d;
            blast_q    <= blast_d;
            err_q      <= err_d;
            tmo_q      <= tmo_d;
            gap_q      <= gap_d;
`ifdef PLL_I2C_SCHED_RETRY_EN
            retry_q    <= retry_d;
            again_q    <= again_d;
`endif
        end
    end

    // Next-state logic: grant, send reg byte, send value byte, ack, STOP gap.
    always_comb begin
        state_d    = state_q;
        owner_sw_d = owner_sw_q;
        last_sw_d  = last_sw_q;
        lock_d     = lock_q;
        reg_d      = reg_q;
        val_d      = val_q;
        blast_d    = blast_q;
        err_d      = err_q;
        tmo_d      = tmo_q;
        gap_d      = gap_q;
`ifdef PLL_I2C_SCHED_RETRY_EN
        retry_d    = retry_q;
        again_d    = again_q;
`endif

        case (state_q)
            S_IDLE: begin
                err_d = 1'b0;
`ifdef PLL_I2C_SCHED_RETRY_EN
                retry_d = '0;
                again_d = 1'b0;
`endif
                if (grant_boot) begin
                    owner_sw_d = 1'b0;
                    last_sw_d  = 1'b0;
                    reg_d      = boot_reg_i;
                    val_d      = boot_value_i;
                    blast_d    = boot_last_i;
                    state_d    = S_GRANT;
                end else if (grant_sw) begin
                    owner_sw_d = 1'b1;
                    last_sw_d  = 1'b1;
                    reg_d      = sw_reg_i;
                    val_d      = sw_value_i;
                    blast_d    = 1'b0;
                    state_d    = S_GRANT;
                end
            end

            S_GRANT: begin
                tmo_d   = '0;
                state_d = S_REG;
            end

            S_REG: begin
                if (i2c_data_ready_i) begin
                    if (nack && can_retry) begin
                        gap_d   = '0;
                        state_d = S_GAP;
`ifdef PLL_I2C_SCHED_RETRY_EN
                        retry_d = retry_q + 1'b1;
                        again_d = 1'b1;
`endif
                    end else if (i2c_addr_err_i) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        err_d   = err_q || i2c_data_err_i;
                        tmo_d   = '0;
                        state_d = S_VAL;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end

            S_VAL: begin
                if (i2c_data_ready_i) begin
                    if (nack && can_retry) begin
                        gap_d   = '0;
                        state_d = S_GAP;
`ifdef PLL_I2C_SCHED_RETRY_EN
                        retry_d = retry_q + 1'b1;
                        again_d = 1'b1;
`endif
                    end else begin
                        err_d   = err_q || nack;
                        state_d = S_DONE;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end

            S_DONE: begin
                if (!owner_sw_q) begin
                    lock_d = !blast_q;
                end
                gap_d   = '0;
                state_d = S_GAP;
            end

            S_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = S_IDLE;
`ifdef PLL_I2C_SCHED_RETRY_EN
                    if (again_q) begin
                        tmo_d   = '0;
                        again_d = 1'b0;
                        state_d = S_REG;
                    end
`endif
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decode straight from the state so reset removes them at once.
    always_comb begin
        busy_o           = (state_q != S_IDLE);
        i2c_cmd_active_o = 1'b0;
        i2c_data_valid_o = 1'b0;
        i2c_data_in_o    = 8'h00;
        boot_ack_o       = 1'b0;
        boot_err_o       = 1'b0;
        sw_ack_o         = 1'b0;
        sw_err_o         = 1'b0;

        case (state_q)
            S_REG: begin
                i2c_cmd_active_o = 1'b1;
                i2c_data_valid_o = 1'b1;
                i2c_data_in_o    = reg_q;
            end
            S_VAL: begin
                i2c_cmd_active_o = 1'b1;
                i2c_data_valid_o = 1'b1;
                i2c_data_in_o    = val_q;
            end
            S_DONE: begin
                i2c_cmd_active_o = 1'b1;
                boot_ack_o       = !owner_sw_q;
                boot_err_o       = !owner_sw_q && err_q;
                sw_ack_o         = owner_sw_q;
                sw_err_o         = owner_sw_q && err_q;
            end
            default: begin
                i2c_cmd_active_o = 1'b0;
            end
        endcase
    end

    assign i2c_cmd_addr_o = I2C_ADDR;

endmodule

// File: tb/tb_pll_i2c_scheduler.sv
// tb_pll_i2c_scheduler
// Directed bench for the PLL-A I2C scheduler: a small I2C byte responder,
// fixed expected bytes/acks per step, and an ack monitor.

module tb_pll_i2c_scheduler;

    logic       clk = 1'b0;
    logic       nreset;
    logic       bootReq;
    logic [7:0] bootReg;
    logic [7:0] bootValue;
    logic       bootLast;
    logic       bootAck;
    logic       bootErr;
    logic       swReq;
    logic [7:0] swReg;
    logic [7:0] swValue;
    logic       swAck;
    logic       swErr;
    logic       busy;
    logic       cmdActive;
    logic [6:0] cmdAddr;
    logic       dataValid;
    logic [7:0] dataIn;
    logic       dataReady;
    logic       addrErr;
    logic       dataErr;

    int compared;
    int mismatched;
    int bootAcks = 0;
    int swAcks = 0;
    int bothAck = 0;

    always #5 clk = ~clk;

    pll_i2c_scheduler #(
        .I2C_ADDR       (7'h60),
        .GAP_CYCLES     (4),
        .TIMEOUT_CYCLES (16),
        .MAX_RETRY      (3)
    ) dut (
        .clk_i            (clk),
        .nreset_i         (nreset),
        .boot_req_i       (bootReq),
        .boot_reg_i       (bootReg),
        .boot_value_i     (bootValue),
        .boot_last_i      (bootLast),
        .boot_ack_o       (bootAck),
        .boot_err_o       (bootErr),
        .sw_req_i         (swReq),
        .sw_reg_i         (swReg),
        .sw_value_i       (swValue),
        .sw_ack_o         (swAck),
        .sw_err_o         (swErr),
        .busy_o           (busy),
        .i2c_cmd_active_o (cmdActive),
        .i2c_cmd_addr_o   (cmdAddr),
        .i2c_data_valid_o (dataValid),
        .i2c_data_in_o    (dataIn),
        .i2c_data_ready_i (dataReady),
        .i2c_addr_err_i   (addrErr),
        .i2c_data_err_i   (dataErr)
    );

    // Ack monitor: counts acks and flags any cycle with both acks high.
    always @(negedge clk) begin
        if (bootAck) bootAcks++;
        if (swAck) swAcks++;
        if (bootAck && swAck) bothAck = 1;
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic bReq, input logic [7:0] bReg,
                                 input logic [7:0] bVal, input logic bLast,
                                 input logic sReq, input logic [7:0] sReg,
                                 input logic [7:0] sVal);
        bootReq   = bReq;
        bootReg   = bReg;
        bootValue = bVal;
        bootLast  = bLast;
        swReq     = sReq;
        swReg     = sReg;
        swValue   = sVal;
    endtask

    // Waits for a valid byte, checks it, then answers with a 1-cycle ready.
    task automatic serveByte(input string tag, input logic [7:0] expByte,
                             input logic aErr, input logic dErr, input int delay);
        int n;
        n = 0;
        while (!dataValid && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, "_valid"}, dataValid, 1'b1);
        checkOutput(tag, dataIn, expByte);
        repeat (delay) @(negedge clk);
        dataReady = 1'b1;
        addrErr   = aErr;
        dataErr   = dErr;
        @(negedge clk);
        dataReady = 1'b0;
        addrErr   = 1'b0;
        dataErr   = 1'b0;
    endtask

    // Waits for the next ack and checks which port got it and its err flag.
    task automatic waitAck(input string tag, input logic expSw, input logic expErr);
        int n;
        n = 0;
        while (!(bootAck || swAck) && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, "_owner"}, {bootAck, swAck}, expSw ? 2'b01 : 2'b10);
        checkOutput({tag, "_err"}, expSw ? swErr : bootErr, expErr);
    endtask

    task automatic waitIdle(input string tag);
        int n;
        n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput(tag, busy, 1'b0);
    endtask

    initial begin
        int n;
        int lim;
        int bk;
        int sk;
        int snap;

        compared   = 0;
        mismatched = 0;
        nreset     = 1'b0;
        dataReady  = 1'b0;
        addrErr    = 1'b0;
        dataErr    = 1'b0;
        applyStimulus(0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);

        // Reset values
        repeat (3) @(negedge clk);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_active", cmdActive, 1'b0);
        checkOutput("rst_valid", dataValid, 1'b0);
        checkOutput("rst_data", dataIn, 8'h00);
        checkOutput("rst_addr", cmdAddr, 7'h60);
        checkOutput("rst_acks", {bootAck, bootErr, swAck, swErr}, 4'h0);
        nreset = 1'b1;
        @(negedge clk);

        // Test 1: single boot write, latency and STOP gap
        $display("[TB] test 1: single boot write");
        applyStimulus(1, 8'h10, 8'hAA, 1, 0, 8'h00, 8'h00);
        n = 0;
        while (!cmdActive && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput("t1_latency", n, 2);
        serveByte("t1_reg", 8'h10, 0, 0, 0);
        serveByte("t1_val", 8'hAA, 0, 0, 1);
        waitAck("t1", 0, 0);
        applyStimulus(0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
        @(negedge clk);
        checkOutput("t1_ack_pulse", bootAck, 1'b0);
        n = 0;
        lim = 0;
        while (busy && lim < 50) begin
            if (!cmdActive) n++;
            lim++;
            @(negedge clk);
        end
        checkOutput("t1_gap", n, 4);

        // Test 2: locked boot burst of 3 while sw waits
        $display("[TB] test 2: boot burst lock");
        applyStimulus(1, 8'h20, 8'h01, 0, 0, 8'h00, 8'h00);
        serveByte("t2_b1_reg", 8'h20, 0, 0, 0);
        applyStimulus(1, 8'h20, 8'h01, 0, 1, 8'h55, 8'h66);
        serveByte("t2_b1_val", 8'h01, 0, 0, 0);
        waitAck("t2_b1", 0, 0);
        applyStimulus(1, 8'h21, 8'h02, 0, 1, 8'h55, 8'h66);
        serveByte("t2_b2_reg", 8'h21, 0, 0, 0);
        serveByte("t2_b2_val", 8'h02, 0, 0, 0);
        waitAck("t2_b2", 0, 0);
        applyStimulus(1, 8'h22, 8'h03, 1, 1, 8'h55, 8'h66);
        serveByte("t2_b3_reg", 8'h22, 0, 0, 0);
        serveByte("t2_b3_val", 8'h03, 0, 0, 0);
        waitAck("t2_b3", 0, 0);
        applyStimulus(0, 8'h00, 8'h00, 0, 1, 8'h55, 8'h66);
        serveByte("t2_sw_reg", 8'h55, 0, 0, 0);
        serveByte("t2_sw_val", 8'h66, 0, 0, 0);
        waitAck("t2_sw", 1, 0);
        applyStimulus(0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
        waitIdle("t2_idle");

        // Test 3: both requesting without lock alternate, boot first
        $display("[TB] test 3: round robin");
        bk = 0;
        sk = 0;
        applyStimulus(1, 8'h30, 8'hB0, 1, 1, 8'h40, 8'hC0);
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) begin
                serveByte("t3_boot_reg", 8'(8'h30 + bk), 0, 0, 0);
                serveByte("t3_boot_val", 8'(8'hB0 + bk), 0, 0, 0);
                waitAck("t3_boot", 0, 0);
                bk++;
            end else begin
                serveByte("t3_sw_reg", 8'(8'h40 + sk), 0, 0, 0);
                serveByte("t3_sw_val", 8'(8'hC0 + sk), 0, 0, 0);
                waitAck("t3_sw", 1, 0);
                sk++;
            end
            applyStimulus(bk < 4, 8'(8'h30 + bk), 8'(8'hB0 + bk), 1,
                          sk < 4, 8'(8'h40 + sk), 8'(8'hC0 + sk));
        end
        waitIdle("t3_idle");

        // Test 4: NACK handling
        $display("[TB] test 4: NACK");
`ifdef PLL_I2C_SCHED_RETRY_EN
        applyStimulus(1, 8'h50, 8'h51, 1, 0, 8'h00, 8'h00);
        for (int a = 0; a < 3; a++) begin
            serveByte("t4_retry_reg", 8'h50, 1, 0, 0);
            checkOutput("t4_retry_noack", bootAck, 1'b0);
            checkOutput("t4_retry_active", cmdActive, 1'b0);
        end
        serveByte("t4_last_reg", 8'h50, 1, 0, 0);
        checkOutput("t4_last_noval", dataValid, 1'b0);
        waitAck("t4_last", 0, 1);
        applyStimulus(0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
        waitIdle("t4_idle_a");
        applyStimulus(0, 8'h00, 8'h00, 0, 1, 8'h60, 8'h61);
        serveByte("t4_sw_nack", 8'h60, 1, 0, 0);
        serveByte("t4_sw_reg", 8'h60, 0, 0, 0);
        serveByte("t4_sw_val", 8'h61, 0, 0, 0);
        waitAck("t4_sw", 1, 0);
`else
        applyStimulus(1, 8'h50, 8'h51, 1, 0, 8'h00, 8'h00);
        serveByte("t4_reg", 8'h50, 1, 0, 0);
        checkOutput("t4_noval", dataValid, 1'b0);
        waitAck("t4_addr", 0, 1);
        applyStimulus(0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
        waitIdle("t4_idle_a");
        applyStimulus(0, 8'h00, 8'h00, 0, 1, 8'h60, 8'h61);
        serveByte("t4_sw_reg", 8'h60, 0, 0, 0);
        serveByte("t4_sw_val", 8'h61, 0, 1, 0);
        waitAck("t4_data", 1, 1);
`endif
        applyStimulus(0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
        waitIdle("t4_idle_b");

        // Test 5: timeout on the REG byte, then a normal write
        $display("[TB] test 5: timeout");
        applyStimulus(1, 8'hA0, 8'hA1, 1, 0, 8'h00, 8'h00);
        n = 0;
        while (!cmdActive && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput("t5_reg_byte", dataIn, 8'hA0);
        n = 0;
        while (!bootAck && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("t5_tmo_cycles", n, 16);
        checkOutput("t5_err", bootErr, 1'b1);
        applyStimulus(0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
        waitIdle("t5_idle_a");
        applyStimulus(0, 8'h00, 8'h00, 0, 1, 8'h70, 8'h71);
        serveByte("t5_sw_reg", 8'h70, 0, 0, 2);
        serveByte("t5_sw_val", 8'h71, 0, 0, 0);
        waitAck("t5_sw", 1, 0);
        applyStimulus(0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
        waitIdle("t5_idle_b");

        // Test 6: reset during the VAL byte
        $display("[TB] test 6: reset mid-transaction");
        applyStimulus(1, 8'h80, 8'h81, 1, 0, 8'h00, 8'h00);
        serveByte("t6_reg", 8'h80, 0, 0, 0);
        checkOutput("t6_val_active", cmdActive, 1'b1);
        checkOutput("t6_val_byte", dataIn, 8'h81);
        applyStimulus(0, 8'h00, 8'h00, 0, 1, 8'h90, 8'h91);
        snap = bootAcks + swAcks;
        #2;
        nreset = 1'b0;
        #1;
        checkOutput("t6_rst_active", cmdActive, 1'b0);
        checkOutput("t6_rst_valid", dataValid, 1'b0);
        checkOutput("t6_rst_busy", busy, 1'b0);
        repeat (2) @(negedge clk);
        nreset = 1'b1;
        checkOutput("t6_no_ack", bootAcks + swAcks, snap);
        serveByte("t6_sw_reg", 8'h90, 0, 0, 0);
        serveByte("t6_sw_val", 8'h91, 0, 0, 0);
        waitAck("t6_sw", 1, 0);
        applyStimulus(0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
        waitIdle("t6_idle");

        checkOutput("never_both_acks", bothAck, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
